en_fire_sched: RTL and testbench

Frame-paced scheduler that shares the single enemy missile channel among N enemy instances. It watches each enemy's alive and request bits and the missile channel's busy flag. Round-robin, it grants one enemy at a time a one-cycle fire pulse, then enforces a level-dependent cooldown counted in video frames. It sits between the per-enemy detect/draw chains and the enemy missile controller, and also reports when the wave is cleared.

---
 rtl/en_fire_sched.sv | 150 +++++++++++++++
 tb/tb_en_fire_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/en_fire_sched.sv
// Round-robin scheduler sharing one enemy missile channel among N enemies,
// with a level-dependent cooldown counted in video frames.
module en_fire_sched #(
  parameter int N         = 4,
  parameter int CD_BASE   = 60,
  parameter int CD_STEP   = 4,
  parameter int CD_MIN    = 8,
  parameter int LAUNCH_TO = 4
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         vsync_in,
  input  logic [3:0]   level,
  input  logic [N-1:0] alive,
  input  logic [N-1:0] req,
  input  logic         missile_busy,
  output logic [N-1:0] fire,
  output logic [2:0]   fire_id,
  output logic         ready,
  output logic         wave_clear
);

  localparam logic [1:0] S_COOL   = 2'd0;
  localparam logic [1:0] S_ARB    = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_FLIGHT = 2'd3;

  localparam logic [7:0]  CD_BASE_V = 8'(CD_BASE);
  localparam logic [7:0]  LT_MAX    = 8'(LAUNCH_TO);
  localparam logic [11:0] CD_BASE_W = 12'(CD_BASE);
  localparam logic [11:0] CD_MIN_W  = 12'(CD_MIN);

  logic [1:0]   state_q, state_d;
  logic [7:0]   cd_q, cd_d;
  logic [2:0]   ptr_q, ptr_d;
  logic [7:0]   lt_q, lt_d;
  logic         vsync_q, vsync_d;
  logic [N-1:0] fire_q, fire_d;
  logic [2:0]   fire_id_q, fire_id_d;
  logic         wave_clear_q, wave_clear_d;

  logic         tick;
  logic [N-1:0] cand;
  logic [2:0]   grant;
  logic [11:0]  prod, diff, rl_w;
  logic [7:0]   rl;

  // First set bit of cand at or after start, wrapping N-1 -> 0. Scanning
  // downward lets the nearest candidate overwrite the farther ones.
  function automatic logic [2:0] rr_pick(input logic [N-1:0] c, input logic [2:0] start);
    logic [N-1:0] rot;
    int           idx;
    rr_pick = start;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N) idx -= N;
      rot = c >> idx;
      if (rot[0]) rr_pick = 3'(idx);
    end
  endfunction

  // Reload: max(CD_BASE - level*CD_STEP, CD_MIN), subtraction saturating at 0.
  always_comb begin
    prod = 12'(level) * 12'(CD_STEP);
    diff = (prod >= CD_BASE_W) ? 12'd0 : CD_BASE_W - prod;
    rl_w = (diff < CD_MIN_W) ? CD_MIN_W : diff;
    rl   = 8'(rl_w);
  end

  assign tick    = vsync_in & ~vsync_q;
  assign vsync_d = vsync_in;
  assign cand    = req & alive;
  assign grant   = rr_pick(cand, ptr_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch); fire_d defaults low to make it a pulse.
    state_d      = state_q;
    cd_d         = cd_q;
    ptr_d        = ptr_q;
    lt_d         = lt_q;
    fire_d       = '0;
    fire_id_d    = fire_id_q;
    wave_clear_d = (alive == '0);

    case (state_q)
      S_COOL: begin
        if (cd_q == 8'd0) state_d = S_ARB;
        else if (tick)    cd_d    = cd_q - 8'd1;
      end
      S_ARB: begin
        if (!missile_busy && cand != '0) begin
          for (int i = 0; i < N; i++) fire_d[i] = (3'(i) == grant);
          fire_id_d = grant;
          ptr_d     = (grant == 3'(N - 1)) ? 3'd0 : grant + 3'd1;
          lt_d      = 8'd0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Busy takes priority over a coincident timeout.
        if (missile_busy) begin
          state_d = S_FLIGHT;
        end else if (tick) begin
          lt_d = lt_q + 8'd1;
          if (lt_d == LT_MAX) begin
            cd_d    = rl;
            state_d = S_COOL;
          end
        end
      end
      S_FLIGHT: begin
        if (!missile_busy) begin
          cd_d    = rl;
          state_d = S_COOL;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= S_COOL;
      cd_q         <= CD_BASE_V;
      ptr_q        <= 3'd0;
      lt_q         <= 8'd0;
      vsync_q      <= 1'b0;
      fire_q       <= '0;
      fire_id_q    <= 3'd0;
      wave_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      ptr_q        <= ptr_d;
      lt_q         <= lt_d;
      vsync_q      <= vsync_d;
      fire_q       <= fire_d;
      fire_id_q    <= fire_id_d;
      wave_clear_q <= wave_clear_d;
    end
  end

  assign fire       = fire_q;
  assign fire_id    = fire_id_q;
  assign ready      = (state_q == S_ARB);
  assign wave_clear = wave_clear_q;

endmodule

// File: tb/tb_en_fire_sched.sv
// Directed bench for en_fire_sched: round-robin order, cooldown clamp,
// busy blocking, launch timeout, wave clear and mid-flight reset.
module tb_en_fire_sched;
  localparam int N = 4;

  logic         pclk = 1'b0;
  logic         rst;
  logic         vsync_in;
  logic [3:0]   level;
  logic [N-1:0] alive;
  logic [N-1:0] req;
  logic         missile_busy;
  logic [N-1:0] fire;
  logic [2:0]   fire_id;
  logic         ready;
  logic         wave_clear;

  logic model_en   = 1'b1;
  logic hold_busy  = 1'b0;
  logic model_busy = 1'b0;
  int   pend       = 0;
  int   flight     = 0;
  int   fire_seen  = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;

  en_fire_sched #(
    .N(N), .CD_BASE(10), .CD_STEP(2), .CD_MIN(4), .LAUNCH_TO(4)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .level(level),
    .alive(alive), .req(req), .missile_busy(missile_busy),
    .fire(fire), .fire_id(fire_id), .ready(ready), .wave_clear(wave_clear)
  );

  always #5 pclk = ~pclk;

  assign missile_busy = model_busy | hold_busy;

  // Missile model: busy rises 2 cycles after a fire pulse and lasts 100 cycles.
  always @(posedge pclk) begin
    #2;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        model_busy = 1'b1;
        flight     = 100;
      end
    end else if (flight > 0) begin
      flight--;
      if (flight == 0) model_busy = 1'b0;
    end
    if (fire != '0) begin
      fire_seen++;
      if (model_en) pend = 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame tick; called and returns on a falling edge.
  task automatic tick();
    vsync_in = 1'b1;
    @(negedge pclk);
    vsync_in = 1'b0;
    @(negedge pclk);
  endtask

  task automatic count_ready(input string tag, input int exp);
    int n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic check_grant(input string tag, input int id);
    @(negedge pclk);
    check({tag, "_fire"}, 32'(fire), 32'(1) << id);
    check({tag, "_id"}, 32'(fire_id), id);
    @(negedge pclk);
    check({tag, "_pulse"}, 32'(fire), 0);
  endtask

  task automatic wait_busy(input string tag, input logic lvl);
    int k = 0;
    while (missile_busy !== lvl && k < 300) begin
      @(negedge pclk);
      k++;
    end
    check(tag, 32'(missile_busy), 32'(lvl));
  endtask

  task automatic finish_flight(input string tag);
    wait_busy({tag, "_up"}, 1'b1);
    wait_busy({tag, "_dn"}, 1'b0);
    @(negedge pclk);
  endtask

  task automatic run_round(input string tag, input int id, input int ticks, input logic [3:0] lvl_after);
    count_ready({tag, "_ticks"}, ticks);
    check_grant(tag, id);
    level = lvl_after;
    finish_flight(tag);
  endtask

  initial begin
    int f0;
    rst = 1'b1; vsync_in = 1'b0; level = 4'd0; alive = 4'hF; req = 4'hF;
    repeat (3) @(negedge pclk);
    check("rst_fire", 32'(fire), 0);
    check("rst_id", 32'(fire_id), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_wclr", 32'(wave_clear), 0);
    rst = 1'b0;

    run_round("r1", 0, 10, 4'd0);
    req = 4'b1011;
    run_round("r2", 1, 10, 4'd0);
    run_round("r3", 3, 10, 4'd0);
    run_round("r4", 0, 10, 4'd2);
    run_round("r5", 1, 6, 4'd5);
    run_round("r6", 3, 4, 4'd15);
    run_round("r7", 0, 4, 4'd0);

    // Busy held through ARB blocks grants; fire follows the fall by one cycle.
    hold_busy = 1'b1;
    count_ready("hb_ticks", 10);
    f0 = fire_seen;
    repeat (50) @(negedge pclk);
    check("hb_nofire", 32'(fire_seen - f0), 0);
    check("hb_ready", 32'(ready), 1);
    hold_busy = 1'b0;
    check_grant("hb", 1);
    finish_flight("hb");

    // Launch timeout: no busy, back to COOL on the 4th tick, ptr advanced.
    model_en = 1'b0;
    count_ready("lt_ticks", 10);
    check_grant("lt", 3);
    repeat (4) tick();
    check("lt_idhold", 32'(fire_id), 3);
    model_en = 1'b1;
    count_ready("lt_cool", 10);
    check_grant("lt2", 0);
    finish_flight("lt2");

    // Wave clear and no grants while nobody is alive.
    alive = 4'b0100; req = 4'hF;
    @(negedge pclk);
    check("wc_lo", 32'(wave_clear), 0);
    alive = 4'b0000;
    @(negedge pclk);
    check("wc_hi", 32'(wave_clear), 1);
    f0 = fire_seen;
    repeat (30) tick();
    check("wc_nofire", 32'(fire_seen - f0), 0);
    check("wc_ready", 32'(ready), 1);
    check("wc_hold", 32'(wave_clear), 1);
    alive = 4'hF;
    @(negedge pclk);
    check("wc_fire", 32'(fire), 32'(4'b0010));
    check("wc_id", 32'(fire_id), 1);
    check("wc_clr", 32'(wave_clear), 0);

    // Reset in the middle of a flight.
    wait_busy("mf_up", 1'b1);
    repeat (5) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    check("mf_fire", 32'(fire), 0);
    check("mf_id", 32'(fire_id), 0);
    check("mf_ready", 32'(ready), 0);
    check("mf_wclr", 32'(wave_clear), 0);
    rst = 1'b0;
    wait_busy("mf_dn", 1'b0);
    count_ready("mf_ticks", 10);
    check_grant("mf", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
